// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller.
//   FIR_NUMTAPS / FIR_COEFW : default tap count and coefficient width
//   fir_ctrl_state_t        : controller FSM states
//   fir_coef_bank_t         : one full coefficient bank at default sizing
package fir_ctrl_pkg;

  localparam int unsigned FIR_NUMTAPS = 32;
  localparam int unsigned FIR_COEFW   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_STB = 2'd1,
    FLUSH    = 2'd2
  } fir_ctrl_state_t;

  typedef logic [FIR_NUMTAPS-1:0][FIR_COEFW-1:0] fir_coef_bank_t;

endpackage : fir_ctrl_pkg

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair.
// Writes land in the shadow bank; a swap copies the whole shadow bank into
// the active bank, which is the only bank visible outside.
// Optional macro FIR_CTRL_READBACK_EN adds a registered shadow read port.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   wr_en              : accepted write (already qualified by the controller)
//   wr_addr, wr_data   : tap index and coefficient value
//   swap               : copy shadow -> active at this edge
//   active             : active bank, registered
//   rd_en, rd_addr     : (readback build) shadow read request
//   rd_data, rd_valid  : (readback build) read result, 1 cycle after rd_en
module fir_coeff_bank
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned NUMTAPS = FIR_NUMTAPS,
  parameter int unsigned COEFW   = FIR_COEFW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(NUMTAPS)-1:0]       wr_addr,
  input  logic [COEFW-1:0]                 wr_data,
  input  logic                             swap,
  output logic [NUMTAPS-1:0][COEFW-1:0]    active
`ifdef FIR_CTRL_READBACK_EN
  ,
  input  logic                             rd_en,
  input  logic [$clog2(NUMTAPS)-1:0]       rd_addr,
  output logic [COEFW-1:0]                 rd_data,
  output logic                             rd_valid
`endif
);

  localparam int unsigned ADDRW = $clog2(NUMTAPS);

  logic [NUMTAPS-1:0][COEFW-1:0] shadow;
  logic                          wr_in_range_c;

  // With a power-of-two tap count every address is legal; otherwise the
  // top of the address space is discarded.
  if (NUMTAPS == (32'd1 << ADDRW)) begin : g_wr_full
    assign wr_in_range_c = 1'b1;
  end else begin : g_wr_part
    assign wr_in_range_c = (32'(wr_addr) < NUMTAPS);
  end

  // Shadow bank: host-visible write target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (wr_en && wr_in_range_c) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // Active bank: changes only on a swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
    end else if (swap) begin
      active <= shadow;
    end
  end

`ifdef FIR_CTRL_READBACK_EN
  logic rd_in_range_c;

  if (NUMTAPS == (32'd1 << ADDRW)) begin : g_rd_full
    assign rd_in_range_c = 1'b1;
  end else begin : g_rd_part
    assign rd_in_range_c = (32'(rd_addr) < NUMTAPS);
  end

  // Shadow readback, one cycle latency; out-of-range reads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range_c ? shadow[rd_addr] : '0;
      end
    end
  end
`endif

endmodule : fir_coeff_bank

// File: rtl/fir_coeff_ctrl.sv
// Coefficient controller for the transposed-form FIR.
// Collects coefficient writes into a shadow bank and installs them into the
// active bank on a sample boundary once a commit is requested. Each swap
// pulses fir_clr and mutes the output for SETTLE further sample strobes.
// Optional macro FIR_CTRL_READBACK_EN adds a shadow readback port.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   wr_valid/wr_ready      : coefficient write handshake (wr_addr, wr_data)
//   commit_req/commit_ack  : level request, one-cycle acknowledge on swap
//   sample_stb             : one pulse per filter input sample
//   coefficients           : active bank to the filter
//   fir_clr                : one-cycle clear of the filter partial sums
//   mute                   : filter output invalid after a swap
//   busy                   : controller not in IDLE
//   rd_en/rd_addr/rd_data/rd_valid : (readback build) shadow read port
module fir_coeff_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned NUMTAPS = FIR_NUMTAPS,
  parameter int unsigned COEFW   = FIR_COEFW,
  parameter int unsigned SETTLE  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [$clog2(NUMTAPS)-1:0]       wr_addr,
  input  logic [COEFW-1:0]                 wr_data,
  input  logic                             commit_req,
  output logic                             commit_ack,
  input  logic                             sample_stb,
  output logic [NUMTAPS-1:0][COEFW-1:0]    coefficients,
  output logic                             fir_clr,
  output logic                             mute,
  output logic                             busy
`ifdef FIR_CTRL_READBACK_EN
  ,
  input  logic                             rd_en,
  input  logic [$clog2(NUMTAPS)-1:0]       rd_addr,
  output logic [COEFW-1:0]                 rd_data,
  output logic                             rd_valid
`endif
);

  localparam int unsigned CNTW = 8;

  fir_ctrl_state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ack_d, clr_d, mute_d;
  logic            swap_c;
  logic            wr_en_c;

  // Handshake and status decode straight from state.
  assign wr_ready = (state_q != WAIT_STB);
  assign busy     = (state_q != IDLE);
  assign wr_en_c  = wr_valid && wr_ready;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      commit_ack <= 1'b0;
      fir_clr    <= 1'b0;
      mute       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      commit_ack <= ack_d;
      fir_clr    <= clr_d;
      mute       <= mute_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    clr_d   = 1'b0;
    mute_d  = mute;
    swap_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (commit_req) begin
          state_d = WAIT_STB;
        end
      end
      WAIT_STB: begin
        // A withdrawn request wins over a coincident strobe.
        if (!commit_req) begin
          state_d = IDLE;
        end else if (sample_stb) begin
          swap_c  = 1'b1;
          ack_d   = 1'b1;
          clr_d   = 1'b1;
          mute_d  = 1'b1;
          cnt_d   = CNTW'(SETTLE);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Counter expiry is seen one cycle after the last decrement, so a
        // free-running strobe keeps mute high for SETTLE+1 cycles.
        if (cnt_q == '0) begin
          mute_d  = 1'b0;
          state_d = IDLE;
        end else if (sample_stb) begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        mute_d  = 1'b0;
      end
    endcase
  end

  fir_coeff_bank #(
    .NUMTAPS (NUMTAPS),
    .COEFW   (COEFW)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en_c),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .swap     (swap_c),
    .active   (coefficients)
`ifdef FIR_CTRL_READBACK_EN
    ,
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`endif
  );

endmodule : fir_coeff_ctrl

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl. Expected active banks are queued
// when a commit is issued and compared when commit_ack appears.
module tb_fir_coeff_ctrl;
  import fir_ctrl_pkg::*;

  localparam int unsigned NT = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned ST = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_valid = 1'b0;
  logic commit_req = 1'b0;
  logic sample_stb = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic wr_ready, commit_ack, fir_clr, mute, busy;
  logic [NT-1:0][CW-1:0] coefficients;
`ifdef FIR_CTRL_READBACK_EN
  logic rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [CW-1:0] rd_data;
  logic rd_valid;
`endif

  int errors = 0;
  int checks = 0;

  fir_coef_bank_t exp_shadow = '0;
  fir_coef_bank_t exp_active = '0;
  fir_coef_bank_t exp_q[$];

  always #5 clk = ~clk;

  fir_coeff_ctrl #(.NUMTAPS(NT), .COEFW(CW), .SETTLE(ST)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit_req   (commit_req),
    .commit_ack   (commit_ack),
    .sample_stb   (sample_stb),
    .coefficients (coefficients),
    .fir_clr      (fir_clr),
    .mute         (mute),
    .busy         (busy)
`ifdef FIR_CTRL_READBACK_EN
    ,
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid)
`endif
  );

  // Scoreboard: every commit_ack must match the oldest queued bank.
  initial begin
    fir_coef_bank_t e;
    forever begin
      @(negedge clk);
      if (!rst && commit_ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: commit_ack=1 with no commit queued");
        end else begin
          e = exp_q.pop_front();
          if (coefficients !== e) begin
            errors++;
            $display("FAIL swap_bank: got=%h exp=%h", coefficients, e);
          end
        end
        checks++;
        if (fir_clr !== 1'b1) begin
          errors++;
          $display("FAIL clr_with_ack: fir_clr=%b exp=1", fir_clr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    exp_shadow[a] = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Issue a commit from IDLE with a strobe in the first WAIT_STB cycle.
  task automatic do_commit();
    exp_q.push_back(exp_shadow);
    exp_active = exp_shadow;
    commit_req = 1'b1;
    @(negedge clk);
    sample_stb = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    sample_stb = 1'b0;
  endtask

  // Hold the strobe high until the controller returns to IDLE (bounded).
  task automatic drain();
    int n;
    n = 0;
    sample_stb = 1'b1;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    sample_stb = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (coefficients !== '0 || wr_ready !== 1'b1 || commit_ack !== 1'b0 ||
        fir_clr !== 1'b0 || mute !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: coef_nonzero=%b rdy=%b ack=%b clr=%b mute=%b busy=%b exp 0 1 0 0 0 0",
               coefficients != '0, wr_ready, commit_ack, fir_clr, mute, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_load();
    for (int i = 0; i < int'(NT); i++) begin
      do_write(AW'(i), CW'(100 + i));
    end
    do_commit();
    checks++;
    if (commit_ack !== 1'b1 || fir_clr !== 1'b1 || mute !== 1'b1) begin
      errors++;
      $display("FAIL load_swap_pulse: ack=%b clr=%b mute=%b exp 1 1 1", commit_ack, fir_clr, mute);
    end
    for (int i = 0; i < int'(NT); i++) begin
      checks++;
      if (coefficients[i] !== CW'(100 + i)) begin
        errors++;
        $display("FAIL load_tap%0d: got=%0d exp=%0d", i, coefficients[i], 100 + i);
      end
    end
    @(negedge clk);
    checks++;
    if (commit_ack !== 1'b0 || fir_clr !== 1'b0 || mute !== 1'b1) begin
      errors++;
      $display("FAIL load_pulse_width: ack=%b clr=%b mute=%b exp 0 0 1", commit_ack, fir_clr, mute);
    end
    for (int k = 0; k < int'(ST); k++) begin
      sample_stb = 1'b1;
      @(negedge clk);
      sample_stb = 1'b0;
      checks++;
      if (mute !== 1'b1) begin
        errors++;
        $display("FAIL load_mute_strobe%0d: mute=%b exp=1", k, mute);
      end
      @(negedge clk);
    end
    checks++;
    if (mute !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_mute_end: mute=%b busy=%b exp 0 0", mute, busy);
    end
  endtask

  task automatic test_strobe_high();
    int n;
    do_write(AW'(0), 16'h8001);
    exp_q.push_back(exp_shadow);
    exp_active = exp_shadow;
    commit_req = 1'b1;
    @(negedge clk);
    sample_stb = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    n = 0;
    while (mute === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    sample_stb = 1'b0;
    checks++;
    if (n != int'(ST) + 1) begin
      errors++;
      $display("FAIL stb_high_mute_len: got=%0d exp=%0d", n, ST + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stb_high_idle: busy=%b exp=0", busy);
    end
  endtask

  task automatic test_collision();
    wr_valid   = 1'b1;
    wr_addr    = AW'(5);
    wr_data    = 16'h7FFF;
    commit_req = 1'b1;
    exp_shadow[5] = 16'h7FFF;
    exp_q.push_back(exp_shadow);
    exp_active = exp_shadow;
    @(negedge clk);
    wr_valid   = 1'b0;
    sample_stb = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    sample_stb = 1'b0;
    checks++;
    if (coefficients[5] !== 16'h7FFF) begin
      errors++;
      $display("FAIL collision_tap5: got=%h exp=7fff", coefficients[5]);
    end
    drain();
  endtask

  task automatic test_withdraw();
    do_write(AW'(9), 16'h5555);
    commit_req = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_wait: busy=%b rdy=%b exp 1 0", busy, wr_ready);
    end
    commit_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_idle: busy=%b rdy=%b exp 0 1", busy, wr_ready);
    end
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (coefficients !== exp_active) begin
      errors++;
      $display("FAIL withdraw_bank: got=%h exp=%h", coefficients, exp_active);
    end
  endtask

  task automatic test_write_wait_flush();
    int n;
    commit_req = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_wr_ready: got=%b exp=0", wr_ready);
    end
    // Write offered in WAIT_STB must be refused.
    wr_valid   = 1'b1;
    wr_addr    = AW'(3);
    wr_data    = 16'hDEAD;
    sample_stb = 1'b1;
    exp_q.push_back(exp_shadow);
    exp_active = exp_shadow;
    @(negedge clk);
    wr_valid   = 1'b0;
    commit_req = 1'b0;
    sample_stb = 1'b0;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_wr_ready: got=%b exp=1", wr_ready);
    end
    do_write(AW'(3), 16'h1234);
    checks++;
    if (coefficients[3] !== exp_active[3]) begin
      errors++;
      $display("FAIL flush_write_leak: got=%h exp=%h", coefficients[3], exp_active[3]);
    end
    // Commit raised during FLUSH waits until IDLE.
    commit_req = 1'b1;
    exp_q.push_back(exp_shadow);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (commit_ack !== 1'b0 || mute !== 1'b1) begin
        errors++;
        $display("FAIL flush_commit_held: ack=%b mute=%b exp 0 1", commit_ack, mute);
      end
    end
    sample_stb = 1'b1;
    n = 0;
    while (commit_ack !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    commit_req = 1'b0;
    sample_stb = 1'b0;
    exp_active = exp_shadow;
    checks++;
    if (commit_ack !== 1'b1) begin
      errors++;
      $display("FAIL flush_commit_timeout: ack=%b exp=1", commit_ack);
    end else if (coefficients[3] !== 16'h1234) begin
      errors++;
      $display("FAIL flush_next_commit_tap3: got=%h exp=1234", coefficients[3]);
    end
    drain();
  endtask

  task automatic test_reset_mid_flush();
    do_commit();
    for (int k = 0; k < 10; k++) begin
      sample_stb = 1'b1;
      @(negedge clk);
      sample_stb = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (mute !== 1'b1 || busy !== 1'b1 || coefficients === '0) begin
      errors++;
      $display("FAIL midflush_pre: mute=%b busy=%b exp 1 1 with loaded bank", mute, busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (coefficients !== '0 || wr_ready !== 1'b1 || commit_ack !== 1'b0 ||
        fir_clr !== 1'b0 || mute !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midflush_reset: coef_nonzero=%b rdy=%b ack=%b clr=%b mute=%b busy=%b exp 0 1 0 0 0 0",
               coefficients != '0, wr_ready, commit_ack, fir_clr, mute, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_shadow = '0;
    exp_active = '0;
    // Shadow must also be cleared: a fresh commit installs all zeros.
    do_commit();
    checks++;
    if (coefficients !== '0) begin
      errors++;
      $display("FAIL midflush_shadow_cleared: got=%h exp=0", coefficients);
    end
    drain();
  endtask

`ifdef FIR_CTRL_READBACK_EN
  task automatic test_readback();
    do_write(AW'(7), 16'hABCD);
    rd_en   = 1'b1;
    rd_addr = AW'(7);
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hABCD) begin
      errors++;
      $display("FAIL readback: valid=%b data=%h exp 1 abcd", rd_valid, rd_data);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL readback_valid_pulse: valid=%b exp=0", rd_valid);
    end
  endtask
`endif

  task automatic test_end();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_commits: got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_load();
    test_strobe_high();
    test_collision();
    test_withdraw();
    test_write_wait_flush();
    test_reset_mid_flush();
`ifdef FIR_CTRL_READBACK_EN
    test_readback();
`endif
    test_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fir_coeff_ctrl

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Coefficient controller for the 32-tap transposed-form FIR. It accepts coefficient writes into a shadow bank over a valid/ready port, and swaps the shadow bank into the active bank only on a sample boundary after a commit handshake. On each swap it clears the filter's partial sums and mutes the output until the pipeline refills. It sits between the host/config bus and the filter's `coefficients` input.

## Interface
Parameters:
- `NUMTAPS`, 32: number of taps and coefficient entries.
- `COEFW`, 16: coefficient width in bits.
- `SETTLE`, 32: number of `sample_stb` pulses the output stays muted after a swap; legal range 1..255.

Ports:
- `clk`  in  1: single clock. All logic runs in this one domain.
- `rst`  in  1: reset, asynchronous and active-high.
- `wr_valid`  in  1: coefficient write request.
- `wr_ready`  out  1: write accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  $clog2(NUMTAPS): tap index, 0..NUMTAPS-1.
- `wr_data`  in  COEFW: coefficient value, signed.
- `commit_req`  in  1: level request to swap banks; hold high until `commit_ack`.
- `commit_ack`  out  1: one-cycle pulse in the swap cycle.
- `sample_stb`  in  1: one-cycle pulse marking each filter input sample.
- `coefficients`  out  [NUMTAPS-1:0][COEFW-1:0]: active bank, driven straight to the filter.
- `fir_clr`  out  1: one-cycle pulse that clears the filter sums. The integrator inverts it into the filter's `rst_n`.
- `mute`  out  1: high while the filter output is invalid after a swap.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- **States:** IDLE, WAIT_STB, FLUSH.
- **IDLE:**
  - `wr_ready`=1.
  - An accepted write updates `shadow[wr_addr]` at the next edge.
  - `commit_req`=1 moves the FSM to WAIT_STB.
- **Write and commit in the same IDLE cycle:** the write is accepted and is included in the commit.
- **WAIT_STB:**
  - `wr_ready`=0.
  - On a `sample_stb` cycle the swap happens at that edge:
    - active bank <= shadow;
    - `commit_ack`, `fir_clr` and `mute` are high in the following cycle;
    - the settle counter is loaded with SETTLE;
    - the FSM goes to FLUSH.
- **Commit withdrawn:** if `commit_req` drops in WAIT_STB before a strobe, the FSM returns to IDLE with no swap.
- **FLUSH:**
  - `wr_ready`=1, so shadow writes are allowed for the next commit.
  - Each `sample_stb` decrements the counter.
  - When the counter reaches 0 the FSM goes to IDLE and `mute` falls in that cycle.
  - `commit_req` in FLUSH is held off and not acknowledged until IDLE.
- **Write address out of range** (`wr_addr` >= NUMTAPS): the write is accepted (`wr_ready` honoured) and discarded.
- **Shadow bank:** never visible on `coefficients`, except through a swap.
- **Reset mid-operation:** returns the FSM to IDLE and zeroes both banks. `fir_clr` is not pulsed by reset, because the filter shares the system reset.

## Timing
- **Reset values:**
  - `coefficients`=0, `wr_ready`=1.
  - `commit_ack`=0, `fir_clr`=0, `mute`=0, `busy`=0.
  - Settle counter=0.
- All outputs are registered except `wr_ready` and `busy`, which decode directly from state.
- **Write latency:** shadow is updated 1 cycle after the accepting edge.
- **Swap latency:** the swap occurs at the first edge where WAIT_STB and `sample_stb` are both true. `coefficients` changes 1 cycle after that `sample_stb` cycle. The earliest swap is 2 cycles after `commit_req` rises, when a strobe arrives in the cycle after entry to WAIT_STB.
- **Strobe in the swap cycle:** this strobe does not count toward SETTLE. The first decrement is on the next strobe.
- **Strobe tied high:** `mute` is high for exactly SETTLE+1 cycles after the swap.
- **Counter width:** 8 bits; it never wraps, because it only decrements while nonzero.

## Configuration
- `FIR_CTRL_READBACK_EN` defined:
  - Adds inputs `rd_en` (1) and `rd_addr` ($clog2(NUMTAPS)).
  - Adds outputs `rd_data` (COEFW) and `rd_valid` (1).
  - `rd_data` returns the **shadow** entry 1 cycle after `rd_en`. Out-of-range `rd_addr` returns 0.
  - Reset value of `rd_data` and `rd_valid` is 0.
- `FIR_CTRL_READBACK_EN` not defined: the ports are absent and there is no readback logic.

## Structure
- **Package `fir_ctrl_pkg`:**
  - Constants `FIR_NUMTAPS`=32 and `FIR_COEFW`=16.
  - The state enum `fir_ctrl_state_t` {IDLE, WAIT_STB, FLUSH}.
  - The typedef `fir_coef_bank_t` = logic [FIR_NUMTAPS-1:0][FIR_COEFW-1:0].
- **Sub-module `fir_coeff_bank`:** the shadow/active register pair, with its write port, swap input and optional read port. The FSM and settle counter stay in `fir_coeff_ctrl`.

## Test plan
- **Reset then load:** reset, write taps 0..31 with value 100+i, hold `commit_req`, pulse `sample_stb` once -> `commit_ack` and `fir_clr` are high for one cycle, then `coefficients[i]`=100+i, and `mute` is high until 32 further strobes.
- **Write/commit collision:** in IDLE, one cycle with `wr_valid` (addr 5, data 0x7FFF) and `commit_req` both high, then a strobe -> active `coefficients[5]`=0x7FFF.
- **Commit withdrawn:** raise `commit_req`, drop it before any strobe -> FSM is back in IDLE, `coefficients` unchanged, no `commit_ack`.
- **Write during WAIT_STB and FLUSH:** `wr_ready`=0 in WAIT_STB; in FLUSH, write addr 3 = 0x1234 -> active `coefficients[3]` is unchanged, and the next commit installs 0x1234.
- **Reset mid-FLUSH:** assert `rst` after 10 of 32 settle strobes -> all outputs at reset values and the active bank is zero.
- **`FIR_CTRL_READBACK_EN` build:** write addr 7 = 0xABCD, then `rd_en` with addr 7 -> `rd_data`=0xABCD and `rd_valid`=1 one cycle later.
